// File: rtl/exu_mdu_sequencer_if.sv
// Request/response bundle between the EXU ALU, the MDU sequencer and the external multiplier/divider.
// The slave modport is the sequencer's view; master is the surrounding pipeline and unit side.
interface exu_mdu_sequencer_if #(
   parameter int XLEN = 64
);
   logic            start_i;
   logic            op_mul_i;
   logic            op_div_i;
   logic            op_rem_i;
   logic            mul_hi_i;
   logic [1:0]      sgn_i;
   logic            word_i;
   logic [XLEN-1:0] da_i;
   logic [XLEN-1:0] db_i;
   logic            flush_i;
   logic            out_ready_i;
   logic            busy_o;
   logic            out_valid_o;
   logic [XLEN-1:0] result_o;
   logic            mdu_flush_o;

   logic            mul_valid_o;
   logic            mulw_o;
   logic [1:0]      mul_signed_o;
   logic [XLEN-1:0] multiplicand_o;
   logic [XLEN-1:0] multiplier_o;
   logic            mul_ready_i;
   logic            mul_out_valid_i;
   logic [XLEN-1:0] result_hi_i;
   logic [XLEN-1:0] result_lo_i;

   logic            div_valid_o;
   logic            divw_o;
   logic            div_signed_o;
   logic [XLEN-1:0] dividend_o;
   logic [XLEN-1:0] divisor_o;
   logic            div_ready_i;
   logic            div_out_valid_i;
   logic [XLEN-1:0] quotient_i;
   logic [XLEN-1:0] remainder_i;

   modport slave (
      input  start_i, op_mul_i, op_div_i, op_rem_i, mul_hi_i, sgn_i, word_i, da_i, db_i,
      input  flush_i, out_ready_i,
      input  mul_ready_i, mul_out_valid_i, result_hi_i, result_lo_i,
      input  div_ready_i, div_out_valid_i, quotient_i, remainder_i,
      output busy_o, out_valid_o, result_o, mdu_flush_o,
      output mul_valid_o, mulw_o, mul_signed_o, multiplicand_o, multiplier_o,
      output div_valid_o, divw_o, div_signed_o, dividend_o, divisor_o
   );

   modport master (
      output start_i, op_mul_i, op_div_i, op_rem_i, mul_hi_i, sgn_i, word_i, da_i, db_i,
      output flush_i, out_ready_i,
      output mul_ready_i, mul_out_valid_i, result_hi_i, result_lo_i,
      output div_ready_i, div_out_valid_i, quotient_i, remainder_i,
      input  busy_o, out_valid_o, result_o, mdu_flush_o,
      input  mul_valid_o, mulw_o, mul_signed_o, multiplicand_o, multiplier_o,
      input  div_valid_o, divw_o, div_signed_o, dividend_o, divisor_o
   );
endinterface

// File: rtl/exu_mdu_sequencer.sv
// Sequences one MUL/DIV/REM micro-op through the external multiplier or divider and
// holds the truncated / sign-extended result until EX2 consumes it.
module exu_mdu_sequencer #(
   parameter int XLEN        = 64,
   parameter bit DIV0_BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   exu_mdu_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MUL_REQ  = 3'd1,
      MUL_WAIT = 3'd2,
      DIV_REQ  = 3'd3,
      DIV_WAIT = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t          state_reg, state_next;
   logic            op_mul_reg, op_rem_reg, mul_hi_reg, word_reg;
   logic [1:0]      sgn_reg;
   logic [XLEN-1:0] da_reg, db_reg;
   logic [XLEN-1:0] result_reg, result_next;
   logic            latch_en;

   logic            div0;
   logic [XLEN-1:0] div0_result;
   logic [XLEN-1:0] mul_sel;
   logic [XLEN-1:0] div_raw;
   logic [XLEN-1:0] div_sel;

   function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
      return {{(XLEN-32){v[31]}}, v[31:0]};
   endfunction

   // W-variants only look at the low word of the divisor for the zero test.
   assign div0        = bus.word_i ? (bus.db_i[31:0] == 32'd0) : (bus.db_i == '0);
   assign div0_result = bus.op_rem_i ? (bus.word_i ? sext32(bus.da_i) : bus.da_i) : '1;

   assign mul_sel = word_reg ? sext32(bus.result_lo_i)
                             : (mul_hi_reg ? bus.result_hi_i : bus.result_lo_i);
   assign div_raw = op_rem_reg ? bus.remainder_i : bus.quotient_i;
   assign div_sel = word_reg ? sext32(div_raw) : div_raw;

   always_comb begin
      state_next  = state_reg;
      result_next = result_reg;
      latch_en    = 1'b0;
      // Flush beats start, unit completion and downstream acceptance alike.
      if (bus.flush_i) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start_i) begin
                  latch_en = 1'b1;
                  if (bus.op_mul_i) begin
                     state_next = MUL_REQ;
                  end else if (bus.op_div_i || bus.op_rem_i) begin
                     if (DIV0_BYPASS && div0) begin
                        state_next  = DONE;
                        result_next = div0_result;
                     end else begin
                        state_next = DIV_REQ;
                     end
                  end
               end
            end
            MUL_REQ: begin
               if (bus.mul_ready_i) state_next = MUL_WAIT;
            end
            MUL_WAIT: begin
               if (bus.mul_out_valid_i) begin
                  state_next  = DONE;
                  result_next = mul_sel;
               end
            end
            DIV_REQ: begin
               if (bus.div_ready_i) state_next = DIV_WAIT;
            end
            DIV_WAIT: begin
               if (bus.div_out_valid_i) begin
                  state_next  = DONE;
                  result_next = div_sel;
               end
            end
            DONE: begin
               if (bus.out_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         op_mul_reg <= 1'b0;
         op_rem_reg <= 1'b0;
         mul_hi_reg <= 1'b0;
         word_reg   <= 1'b0;
         sgn_reg    <= 2'b00;
         da_reg     <= '0;
         db_reg     <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         result_reg <= result_next;
         if (latch_en) begin
            op_mul_reg <= bus.op_mul_i;
            op_rem_reg <= bus.op_rem_i;
            mul_hi_reg <= bus.mul_hi_i;
            word_reg   <= bus.word_i;
            sgn_reg    <= bus.sgn_i;
            da_reg     <= bus.da_i;
            db_reg     <= bus.db_i;
         end
      end
   end

   assign bus.busy_o      = ((state_reg != IDLE) && !((state_reg == DONE) && bus.out_ready_i))
                          || ((state_reg == IDLE) && bus.start_i);
   assign bus.out_valid_o = (state_reg == DONE);
   assign bus.result_o    = result_reg;
   assign bus.mdu_flush_o = bus.flush_i && !rst;

   // Operands come straight from the latch, so they cannot move while valid is high.
   assign bus.mul_valid_o    = (state_reg == MUL_REQ);
   assign bus.mulw_o         = op_mul_reg && word_reg;
   assign bus.mul_signed_o   = op_mul_reg ? sgn_reg : 2'b00;
   assign bus.multiplicand_o = da_reg;
   assign bus.multiplier_o   = db_reg;

   assign bus.div_valid_o    = (state_reg == DIV_REQ);
   assign bus.divw_o         = !op_mul_reg && word_reg;
   assign bus.div_signed_o   = !op_mul_reg && sgn_reg[1];
   assign bus.dividend_o     = da_reg;
   assign bus.divisor_o      = db_reg;
endmodule

// File: tb/tb_exu_mdu_sequencer.sv
// Directed bench for exu_mdu_sequencer; the bench plays the ALU, EX2 and both arithmetic units.
module tb_exu_mdu_sequencer;
   localparam int XLEN = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   exu_mdu_sequencer_if #(.XLEN(XLEN)) bus();

   exu_mdu_sequencer #(.XLEN(XLEN), .DIV0_BYPASS(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic m, input logic d, input logic r, input logic hi,
                        input logic [1:0] sgn, input logic w, input logic [63:0] a, input logic [63:0] b);
      bus.start_i  = 1'b1;
      bus.op_mul_i = m;
      bus.op_div_i = d;
      bus.op_rem_i = r;
      bus.mul_hi_i = hi;
      bus.sgn_i    = sgn;
      bus.word_i   = w;
      bus.da_i     = a;
      bus.db_i     = b;
      #1 chk("busy_on_start", bus.busy_o, 1);
      step();
      bus.start_i  = 1'b0;
      bus.op_mul_i = 1'b0;
      bus.op_div_i = 1'b0;
      bus.op_rem_i = 1'b0;
      bus.mul_hi_i = 1'b0;
      bus.sgn_i    = 2'b00;
      bus.word_i   = 1'b0;
      bus.da_i     = 64'hDEAD_BEEF_0BAD_F00D;
      bus.db_i     = 64'h0123_4567_89AB_CDEF;
      #1;
   endtask

   task automatic mul_unit(input int rdy_dly, input int out_dly, input logic [63:0] hi, input logic [63:0] lo);
      for (int i = 0; i < rdy_dly; i++) begin
         chk("mul_valid_hold", bus.mul_valid_o, 1);
         step();
      end
      bus.mul_ready_i = 1'b1;
      #1 chk("mul_valid_hs", bus.mul_valid_o, 1);
      step();
      bus.mul_ready_i = 1'b0;
      #1 chk("mul_valid_drop", bus.mul_valid_o, 0);
      for (int i = 0; i < out_dly; i++) begin
         chk("mul_wait_busy", bus.busy_o, 1);
         step();
      end
      bus.mul_out_valid_i = 1'b1;
      bus.result_hi_i     = hi;
      bus.result_lo_i     = lo;
      step();
      bus.mul_out_valid_i = 1'b0;
      #1;
   endtask

   task automatic div_unit(input int rdy_dly, input int out_dly, input logic [63:0] q, input logic [63:0] r);
      for (int i = 0; i < rdy_dly; i++) begin
         chk("div_valid_hold", bus.div_valid_o, 1);
         step();
      end
      bus.div_ready_i = 1'b1;
      #1 chk("div_valid_hs", bus.div_valid_o, 1);
      step();
      bus.div_ready_i = 1'b0;
      #1 chk("div_valid_drop", bus.div_valid_o, 0);
      for (int i = 0; i < out_dly; i++) begin
         chk("div_wait_noresult", bus.out_valid_o, 0);
         step();
      end
      bus.div_out_valid_i = 1'b1;
      bus.quotient_i      = q;
      bus.remainder_i     = r;
      step();
      bus.div_out_valid_i = 1'b0;
      #1;
   endtask

   task automatic take(input string name, input logic [63:0] exp, input int hold);
      logic [63:0] seen;
      seen = bus.result_o;
      chk({name, "_valid"}, bus.out_valid_o, 1);
      chk({name, "_result"}, seen, exp);
      for (int i = 0; i < hold; i++) begin
         step();
         chk({name, "_hold_valid"}, bus.out_valid_o, 1);
         chk({name, "_hold_result"}, bus.result_o, exp);
         chk({name, "_hold_busy"}, bus.busy_o, 1);
      end
      bus.out_ready_i = 1'b1;
      #1 chk({name, "_busy_drop"}, bus.busy_o, 0);
      step();
      bus.out_ready_i = 1'b0;
      #1 chk({name, "_valid_drop"}, bus.out_valid_o, 0);
      $display("txn %s result=0x%016h", name, seen);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start_i = 0; bus.op_mul_i = 0; bus.op_div_i = 0; bus.op_rem_i = 0;
      bus.mul_hi_i = 0; bus.sgn_i = 0; bus.word_i = 0; bus.da_i = 0; bus.db_i = 0;
      bus.flush_i = 0; bus.out_ready_i = 0;
      bus.mul_ready_i = 0; bus.mul_out_valid_i = 0; bus.result_hi_i = 0; bus.result_lo_i = 0;
      bus.div_ready_i = 0; bus.div_out_valid_i = 0; bus.quotient_i = 0; bus.remainder_i = 0;

      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_result", bus.result_o, 0);
      chk("rst_mul_valid", bus.mul_valid_o, 0);
      chk("rst_div_valid", bus.div_valid_o, 0);
      chk("rst_mdu_flush", bus.mdu_flush_o, 0);

      // MUL s*s -3 * 7, low half, unit slow to accept and to answer
      issue(1, 0, 0, 0, 2'b11, 0, -64'sd3, 64'd7);
      chk("mul_multiplicand", bus.multiplicand_o, 64'hFFFF_FFFF_FFFF_FFFD);
      chk("mul_multiplier", bus.multiplier_o, 64'd7);
      chk("mul_signed", bus.mul_signed_o, 2'b11);
      chk("mul_div_valid", bus.div_valid_o, 0);
      mul_unit(2, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB);
      take("mul_ss", 64'hFFFF_FFFF_FFFF_FFEB, 0);

      // MULW u*u: word product 0x1_0000_0000 truncates to 0
      issue(1, 0, 0, 0, 2'b00, 1, 64'h1_8000_0000, 64'd2);
      chk("mulw_flag", bus.mulw_o, 1);
      chk("mulw_signed", bus.mul_signed_o, 2'b00);
      mul_unit(0, 0, 64'd0, 64'h1_0000_0000);
      take("mulw_uu", 64'd0, 0);

      // MULHU all-ones * 2, minimum latency
      issue(1, 0, 0, 1, 2'b00, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      mul_unit(0, 0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE);
      take("mulhu", 64'd1, 0);

      // DIV / REM signed -20 by 6, divider answers after 10 cycles
      issue(0, 1, 0, 0, 2'b10, 0, -64'sd20, 64'd6);
      chk("div_signed", bus.div_signed_o, 1);
      chk("div_divw", bus.divw_o, 0);
      chk("div_dividend", bus.dividend_o, 64'hFFFF_FFFF_FFFF_FFEC);
      chk("div_divisor", bus.divisor_o, 64'd6);
      chk("div_mul_valid", bus.mul_valid_o, 0);
      div_unit(0, 10, -64'sd3, -64'sd2);
      take("div_s", 64'hFFFF_FFFF_FFFF_FFFD, 0);
      issue(0, 0, 1, 0, 2'b10, 0, -64'sd20, 64'd6);
      div_unit(1, 10, -64'sd3, -64'sd2);
      take("rem_s", 64'hFFFF_FFFF_FFFF_FFFE, 3);

      // Divide-by-zero bypass: result ready one cycle after start, divider untouched
      issue(0, 1, 0, 0, 2'b00, 0, 64'd100, 64'd0);
      chk("divu0_div_valid", bus.div_valid_o, 0);
      take("divu0", 64'hFFFF_FFFF_FFFF_FFFF, 0);
      issue(0, 0, 1, 0, 2'b10, 1, 64'h1_FFFF_FFF5, 64'd0);
      chk("remw0_div_valid", bus.div_valid_o, 0);
      take("remw0", 64'hFFFF_FFFF_FFFF_FFF5, 0);
      issue(0, 1, 0, 0, 2'b10, 1, 64'd77, 64'h5_0000_0000);
      chk("divw0_div_valid", bus.div_valid_o, 0);
      take("divw0_hi_nonzero", 64'hFFFF_FFFF_FFFF_FFFF, 0);

      // Flush in DIV_WAIT, then a late divider answer must be ignored
      issue(0, 1, 0, 0, 2'b10, 0, -64'sd20, 64'd6);
      bus.div_ready_i = 1'b1;
      step();
      bus.div_ready_i = 1'b0;
      step();
      bus.flush_i = 1'b1;
      #1 chk("flush_div_pulse", bus.mdu_flush_o, 1);
      step();
      bus.flush_i = 1'b0;
      #1;
      chk("flush_div_pulse_end", bus.mdu_flush_o, 0);
      chk("flush_div_busy", bus.busy_o, 0);
      chk("flush_div_valid", bus.out_valid_o, 0);
      step();
      bus.div_out_valid_i = 1'b1;
      bus.quotient_i      = 64'd5;
      step();
      bus.div_out_valid_i = 1'b0;
      #1;
      chk("late_div_valid", bus.out_valid_o, 0);
      chk("late_div_busy", bus.busy_o, 0);
      $display("txn flush_div dropped");
      issue(1, 0, 0, 0, 2'b11, 0, 64'd5, 64'd6);
      mul_unit(0, 1, 64'd0, 64'd30);
      take("mul_after_flush", 64'd30, 0);

      // Flush coinciding with the multiplier's answer
      issue(1, 0, 0, 0, 2'b11, 0, 64'd9, 64'd11);
      bus.mul_ready_i = 1'b1;
      step();
      bus.mul_ready_i     = 1'b0;
      bus.mul_out_valid_i = 1'b1;
      bus.result_lo_i     = 64'd99;
      bus.flush_i         = 1'b1;
      #1 chk("flush_mul_pulse", bus.mdu_flush_o, 1);
      step();
      bus.mul_out_valid_i = 1'b0;
      bus.flush_i         = 1'b0;
      #1;
      chk("flush_mul_valid", bus.out_valid_o, 0);
      chk("flush_mul_busy", bus.busy_o, 0);
      $display("txn flush_mul dropped");

      // Flush in IDLE drops a same-cycle start
      bus.start_i  = 1'b1;
      bus.op_mul_i = 1'b1;
      bus.flush_i  = 1'b1;
      #1 chk("flush_idle_pulse", bus.mdu_flush_o, 1);
      step();
      bus.start_i  = 1'b0;
      bus.op_mul_i = 1'b0;
      bus.flush_i  = 1'b0;
      #1;
      chk("flush_idle_mul_valid", bus.mul_valid_o, 0);
      chk("flush_idle_busy", bus.busy_o, 0);
      $display("txn flush_idle start dropped");

      // Synchronous reset while requesting the multiplier
      issue(1, 0, 0, 0, 2'b11, 1, 64'd7, 64'd9);
      chk("pre_rst_mul_valid", bus.mul_valid_o, 1);
      chk("pre_rst_mulw", bus.mulw_o, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_mul_valid", bus.mul_valid_o, 0);
      chk("mid_rst_mulw", bus.mulw_o, 0);
      chk("mid_rst_mul_signed", bus.mul_signed_o, 0);
      chk("mid_rst_multiplicand", bus.multiplicand_o, 0);
      chk("mid_rst_multiplier", bus.multiplier_o, 0);
      chk("mid_rst_out_valid", bus.out_valid_o, 0);
      chk("mid_rst_busy", bus.busy_o, 0);
      chk("mid_rst_result", bus.result_o, 0);
      $display("txn reset_mid_op");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/exu_mdu_sequencer.md
Name: exu_mdu_sequencer

Overview:
- Sequences the external multi-cycle multiplier and divider for the EXU ALU.
- Accepts one decoded MUL/DIV/REM micro-op at a time and latches its operands.
- Drives the valid/ready handshake to the selected unit, then selects, truncates and sign-extends the result.
- Holds the result until the EX2 stage consumes it; aborts cleanly on a branch flush. Fast ALU ops never pass through this block.

Parameters:
- XLEN, 64, datapath width.
- DIV0_BYPASS, 1, when 1, divide-by-zero is resolved locally without issuing to the divider.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start_i  in  1  one-cycle request pulse from ALU decode; sampled only in IDLE
- op_mul_i  in  1  multiply op (exactly one of op_mul_i/op_div_i/op_rem_i is set with start_i)
- op_div_i  in  1  divide op, quotient result
- op_rem_i  in  1  remainder op
- mul_hi_i  in  1  return high half of product (MULH*); else low half
- sgn_i  in  2  mul: 2'b11 s*s, 2'b10 s*u, 2'b00 u*u; div/rem: bit1 = signed
- word_i  in  1  W-variant (32-bit op, sign-extended result)
- da_i  in  XLEN  operand A (multiplicand / dividend)
- db_i  in  XLEN  operand B (multiplier / divisor)
- flush_i  in  1  EX1 branch flush; aborts any in-flight op
- out_ready_i  in  1  downstream (EX2 not stalled) accepts result
- busy_o  out  1  request upstream stall
- out_valid_o  out  1  result valid
- result_o  out  XLEN  final result
- mdu_flush_o  out  1  abort pulse to both units
- mul_valid_o, mulw_o  out  1 each
- mul_signed_o  out  2
- multiplicand_o, multiplier_o  out  XLEN
- mul_ready_i, mul_out_valid_i  in  1 each
- result_hi_i, result_lo_i  in  XLEN
- div_valid_o, divw_o, div_signed_o  out  1 each
- dividend_o, divisor_o  out  XLEN
- div_ready_i, div_out_valid_i  in  1 each
- quotient_i, remainder_i  in  XLEN

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs 0, state IDLE, operand/result registers 0.
- States: IDLE, MUL_REQ, MUL_WAIT, DIV_REQ, DIV_WAIT, DONE.
- IDLE, start_i=1:
  - Latch operands, op, sgn and word.
  - Mul → MUL_REQ. Div/rem → DIV_REQ.
  - Div/rem with DIV0_BYPASS=1 and divisor zero (low 32 bits when word_i) → DONE directly.
  - busy_o asserts combinationally the same cycle.
- MUL_REQ: mul_valid_o=1 with latched operands, mulw_o and mul_signed_o. Advance to MUL_WAIT on mul_ready_i=1 (handshake cycle).
- MUL_WAIT: on mul_out_valid_i, capture the result and go to DONE.
  - Result is result_hi_i if mul_hi else result_lo_i.
  - Word: sign-extend bit 31 of result_lo_i.
- DIV_REQ and DIV_WAIT mirror MUL_REQ and MUL_WAIT.
  - Capture quotient_i for div, remainder_i for rem.
  - Word: sign-extend bit 31.
- Div-by-zero bypass result:
  - div: all-ones (XLEN).
  - rem: dividend (word: sign-extended low 32).
- DONE: out_valid_o=1, result_o stable. On out_ready_i=1 → IDLE.
- busy_o = (state != IDLE && !(DONE && out_ready_i)) || (IDLE && start_i).
- Valid outputs to the units are held until their ready; operands must not change while valid is high.
- Latency, with same-cycle ready and out_valid: start→REQ (1) → WAIT (1) → DONE (1 after out_valid). Result is visible 3 cycles after start at minimum.
- flush_i in any non-IDLE state:
  - mdu_flush_o=1 that cycle.
  - Next state IDLE; out_valid_o deasserted next cycle.
  - Late mul_out_valid_i/div_out_valid_i are ignored.
  - flush_i has priority over start_i and over out_valid capture in the same cycle.
- flush_i in IDLE: mdu_flush_o=1, no state change; start_i in the same cycle is dropped.
- Unit out_valid outside its WAIT state: ignored.
- rst mid-operation: immediate IDLE. Units are reset by their own rst; no mdu_flush_o needed.

Test Plan:
- MUL s*s, da=-3, db=7, mul_hi=0, ready/out_valid after 2 cycles → mul_valid held until ready. result_o=0xFFFF_FFFF_FFFF_FFEB, out_valid_o 1 cycle with out_ready_i=1, busy_o drops the same cycle.
- MULW u*u, da=0x1_8000_0000, db=2 → mulw_o=1, result_o=0x0000_0000_0000_0000 (low 32 of 0x1_0000_0000 sign-ext). MULHU 0xFFFF..FF × 2 → result_o=1.
- DIV signed, da=-20, db=6, divider out_valid after 10 cycles → result_o=-3. REM same operands → -2. out_ready_i low 3 cycles: result held, busy_o=1.
- DIVU, db=0 with DIV0_BYPASS=1 → div_valid_o never asserts, DONE after 1 cycle, result_o=all-ones. REMW, da=0x1_FFFF_FFF5, db=0 → result_o=0xFFFF_FFFF_FFFF_FFF5.
- Flush in DIV_WAIT, then div_out_valid_i pulses 2 cycles later → mdu_flush_o 1-cycle pulse, out_valid_o never asserts, state IDLE. A new MUL start the next cycle completes correctly.
- Simultaneous flush_i with mul_out_valid_i in MUL_WAIT → no result, IDLE. Synchronous rst in MUL_REQ → all outputs 0 next cycle.
